flit_tx_port: RTL

- Upstream link transmitter (network-interface injection side) that feeds a router input buffer.
- Accepts a word stream from the core and segments each packet into 64-bit flits.
- Allocates one of two VCs per packet and holds that VC through the tail (wormhole).
- Drives flit/valid/VC into the downstream buffer, throttled by the buffer's per-VC not-full status.

---
 rtl/flit_tx_port.sv | 104 ++++++++++
 1 files changed

// File: rtl/flit_tx_port.sv
// Network-interface injection port: segments core words into 64-bit flits,
// allocates one of two VCs per packet, and drives a flow-controlled holding register.
//
// state  | meaning
// IDLE   | next accepted word is a head (type 000 or 011)
// ACTIVE | packet open; next word is body (001) or tail (010)
module flit_tx_port #(
  parameter logic [5:0] SRC_ID = 6'd0,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic [5:0]       in_dest,
  output logic [63:0]      tx_flit,
  output logic             tx_valid,
  output logic [1:0]       tx_vc,
  input  logic [1:0]       vc_status,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state;
  logic [63:0] hold_flit;
  logic        hold_vc;
  logic        hold_valid;
  logic        rr;
  logic        cur_vc;
  logic [5:0]  dest_q;

  logic        tx_fire;
  logic        in_fire;
  logic        alloc_vc;
  logic [2:0]  flit_type;
  logic [5:0]  flit_dest;
  logic        flit_vc;
  logic        tail_sent;

  assign tx_valid  = hold_valid & vc_status[hold_vc];
  assign tx_fire   = tx_valid;
  assign in_ready  = !hold_valid | tx_fire;
  assign in_fire   = in_valid & in_ready;
  assign tx_flit   = hold_flit;
  assign tx_vc     = {1'b0, hold_vc};
  assign busy      = (state == ACTIVE) | hold_valid;

  // Prefer the round-robin VC; only skip when it is full and the other has room.
  assign alloc_vc  = (!vc_status[rr] && vc_status[~rr]) ? ~rr : rr;

  always_comb begin
    flit_type = 3'b000;
    flit_dest = in_dest;
    flit_vc   = alloc_vc;
    if (state == IDLE) begin
      flit_type = in_last ? 3'b011 : 3'b000;
    end else begin
      flit_type = in_last ? 3'b010 : 3'b001;
      flit_dest = dest_q;
      flit_vc   = cur_vc;
    end
  end

  assign tail_sent = tx_fire & ((hold_flit[57:55] == 3'b010) | (hold_flit[57:55] == 3'b011));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_flit  <= 64'd0;
      hold_vc    <= 1'b0;
      hold_valid <= 1'b0;
      rr         <= 1'b0;
      cur_vc     <= 1'b0;
      dest_q     <= 6'd0;
      pkt_count  <= '0;
    end else begin
      if (in_fire) begin
        hold_flit  <= {SRC_ID, flit_type, flit_dest, 17'd0, in_data};
        hold_vc    <= flit_vc;
        hold_valid <= 1'b1;
        case (state)
          IDLE: begin
            dest_q <= in_dest;
            cur_vc <= alloc_vc;
            rr     <= ~alloc_vc;
            if (!in_last) state <= ACTIVE;
          end
          ACTIVE: begin
            if (in_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (tx_fire) begin
        hold_valid <= 1'b0;
      end
      if (tail_sent) pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule
